// File: rtl/load_store_unit.sv
// Load/store unit: turns pipeline access requests into registered memory cycles,
// splitting misaligned halfword/word accesses into big-endian byte accesses.
module load_store_unit #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  mem_A,
  output logic [31:0] mem_DI,
  input  logic [31:0] mem_DO,
  output logic [1:0]  mem_Size,
  output logic        mem_RW,
  output logic        mem_E
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACC, SPLIT, RESP} state_t;

  state_t      state;
  state_t      state_next;

  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  cnt;
  logic [31:0] shreg;

  logic [7:0]  mem_a_n;
  logic [31:0] mem_di_n;
  logic [1:0]  mem_size_n;
  logic        mem_rw_n;
  logic        mem_e_n;
  logic        resp_valid_n;
  logic        resp_err_n;
  logic [31:0] resp_rdata_n;
  logic [1:0]  cnt_n;
  logic [31:0] shreg_n;

  logic        req_misaligned;
  logic        req_bad;
  logic [1:0]  last_cnt;

  function automatic logic [31:0] extend_load(input logic [31:0] data, input logic [1:0] size,
                                              input logic sgn);
    case (size)
      SZ_BYTE: return {{24{sgn & data[7]}}, data[7:0]};
      SZ_HALF: return {{16{sgn & data[15]}}, data[15:0]};
      default: return data;
    endcase
  endfunction

  // Byte k of an N-byte access is the k-th most significant byte of the data
  function automatic logic [7:0] pick_byte(input logic [31:0] data, input logic [1:0] size,
                                           input logic [1:0] k);
    logic [1:0] idx;
    idx = ((size == SZ_WORD) ? 2'd3 : 2'd1) - k;
    return data[{idx, 3'b000} +: 8];
  endfunction

  assign req_ready      = (state == IDLE);
  assign req_misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                          ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign req_bad        = (req_size == SZ_ILL) || (req_misaligned && !SPLIT_MISALIGNED);
  assign last_cnt       = (size_q == SZ_WORD) ? 2'd3 : 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad)             state_next = RESP;
          else if (req_misaligned) state_next = SPLIT;
          else                     state_next = ACC;
        end
      end
      ACC:     state_next = RESP;
      SPLIT:   state_next = (cnt == last_cnt) ? RESP : SPLIT;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values for the registered memory and response outputs
  always_comb begin
    mem_a_n      = mem_A;
    mem_di_n     = mem_DI;
    mem_size_n   = mem_Size;
    mem_rw_n     = 1'b0;
    mem_e_n      = 1'b0;
    resp_valid_n = 1'b0;
    resp_err_n   = 1'b0;
    resp_rdata_n = 32'd0;
    cnt_n        = cnt;
    shreg_n      = shreg;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_n   = 2'd0;
          shreg_n = 32'd0;
          if (req_bad) begin
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
          end else begin
            mem_a_n  = req_addr;
            mem_rw_n = req_we;
            mem_e_n  = req_we;
            if (req_misaligned) begin
              mem_size_n = SZ_BYTE;
              if (req_we) mem_di_n = {24'd0, pick_byte(req_wdata, req_size, 2'd0)};
            end else begin
              mem_size_n = req_size;
              if (req_we) mem_di_n = extend_load(req_wdata, req_size, 1'b0);
            end
          end
        end
      end
      ACC: begin
        resp_valid_n = 1'b1;
        if (!we_q) resp_rdata_n = extend_load(mem_DO, size_q, signed_q);
      end
      SPLIT: begin
        shreg_n = {shreg[23:0], mem_DO[7:0]};
        if (cnt == last_cnt) begin
          cnt_n        = 2'd0;
          resp_valid_n = 1'b1;
          if (!we_q) resp_rdata_n = extend_load(shreg_n, size_q, signed_q);
        end else begin
          cnt_n    = cnt + 2'd1;
          mem_a_n  = addr_q + {6'd0, cnt_n};
          mem_rw_n = we_q;
          mem_e_n  = we_q;
          if (we_q) mem_di_n = {24'd0, pick_byte(wdata_q, size_q, cnt_n)};
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_A      <= 8'd0;
      mem_DI     <= 32'd0;
      mem_Size   <= SZ_BYTE;
      mem_RW     <= 1'b0;
      mem_E      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      cnt        <= 2'd0;
      shreg      <= 32'd0;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      addr_q     <= 8'd0;
      wdata_q    <= 32'd0;
    end else begin
      mem_A      <= mem_a_n;
      mem_DI     <= mem_di_n;
      mem_Size   <= mem_size_n;
      mem_RW     <= mem_rw_n;
      mem_E      <= mem_e_n;
      resp_valid <= resp_valid_n;
      resp_err   <= resp_err_n;
      resp_rdata <= resp_rdata_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      if (state == IDLE && req_valid) begin
        we_q     <= req_we;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SPLIT_MISALIGNED, default 1: 1 = split misaligned accesses into byte accesses; 0 = reject them with resp_err.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  pipeline presents an access request.
REQ-005 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 req_we  input  1  0 = load, 1 = store.
REQ-007 req_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-008 req_signed  input  1  sign-extend a byte or halfword load; 0 = zero-extend.
REQ-009 req_addr  input  8  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle pulse that completes a request.
REQ-012 resp_rdata  output  32  load result; 0 for stores and errors.
REQ-013 resp_err  output  1  qualifies resp_valid; illegal size, or misaligned access when SPLIT_MISALIGNED=0.
REQ-014 mem_A  output  8  memory byte address.
REQ-015 mem_DI  output  32  memory write data, right-justified per mem_Size.
REQ-016 mem_DO  input  32  memory read data; combinational from mem_A, mem_Size and mem_RW.
REQ-017 mem_Size  output  2  memory access size, same encoding as req_size.
REQ-018 mem_RW  output  1  0 = read, 1 = write.
REQ-019 mem_E  output  1  memory write enable.

Function
REQ-020 The unit SHALL register all mem_* and resp_* outputs.
REQ-021 The FSM SHALL have four states: IDLE, ACC, SPLIT and RESP.
REQ-022 A request SHALL be accepted in cycle T when req_valid and req_ready are both high, and all req_* fields SHALL be latched then.
REQ-023 Alignment SHALL be: byte always aligned; halfword aligned when addr[0]=0; word aligned when addr[1:0]=00.
REQ-024 Aligned request: IDLE->ACC; in cycle T+1 drive mem_A=addr, mem_Size=size, mem_RW=we, mem_E=we, and capture mem_DO at the end of T+1.
REQ-025 From ACC the FSM SHALL go to RESP, with resp_valid high in T+2.
REQ-026 Misaligned request with SPLIT_MISALIGNED=1: IDLE->SPLIT, then N byte accesses (N=2 halfword, N=4 word) in cycles T+1..T+N with mem_Size=00 and mem_A=addr+k (k=0..N-1).
REQ-027 Split accesses SHALL keep big-endian order: byte k of the access maps to data bits [8*(N-1-k)+7 : 8*(N-1-k)].
REQ-028 For split accesses resp_valid SHALL be high in T+N+1.
REQ-029 A byte counter (2 bits) SHALL step through the split, and mem_A arithmetic SHALL wrap modulo 256 (addr 0xFF, k=1 -> 0x00).
REQ-030 For split stores mem_DI[7:0] SHALL carry the selected byte, mem_E=1 in each of the N cycles, and mem_DI[31:8]=0.
REQ-031 For split loads the bytes SHALL be assembled into a 32-bit shift register before the response.
REQ-032 Illegal size or rejected misaligned request: IDLE->RESP with no memory cycle and mem_E held 0.
REQ-033 In that case resp_valid=1, resp_err=1 and resp_rdata=0 in T+1.
REQ-034 Load result: byte/halfword zero- or sign-extended from bit 7/15 per req_signed; word passed unchanged.
REQ-035 RESP SHALL return to IDLE unconditionally; resp_valid is exactly one cycle and has no backpressure.
REQ-036 req_ready SHALL be low from T+1 until the cycle after RESP, so a new request is accepted no earlier than the cycle after resp_valid.
REQ-037 In IDLE and RESP: mem_E=0, mem_RW=0; mem_A, mem_Size and mem_DI hold their last values.
REQ-038 mem_E SHALL never be high when mem_RW=0.
REQ-039 req_valid while req_ready=0 SHALL be ignored and not queued.

Reset
REQ-040 When rst_n=0, the unit SHALL asynchronously enter IDLE and drive req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_A=0, mem_DI=0, mem_Size=00, mem_RW=0, mem_E=0, and clear the counter and shift register.
REQ-041 Reset mid-access SHALL abort the transaction: no response, and mem_E drops immediately without waiting for clk.
REQ-042 After rst_n deasserts, the first request SHALL be accepted on the first rising edge with req_valid=1.

Verification
REQ-043 Aligned word load, addr 0x04, memory bytes 04..07 = 11 22 33 44 -> resp_valid at T+2, resp_rdata=0x11223344, resp_err=0.
REQ-044 Signed byte load, addr 0x10 = 0x80 -> resp_rdata=0xFFFFFF80; the same request with req_signed=0 -> 0x00000080.
REQ-045 Misaligned word store 0xAABBCCDD to 0xFE with SPLIT_MISALIGNED=1 -> byte writes FE=AA, FF=BB, 00=CC, 01=DD in T+1..T+4, resp_valid at T+5.
REQ-046 Misaligned halfword load at 0x03 with SPLIT_MISALIGNED=0 -> resp_err=1 at T+1, resp_rdata=0, no mem_E pulse.
REQ-047 req_size=11 store -> resp_err=1 at T+1 and mem_E stays 0.
REQ-048 rst_n low during cycle T+2 of a split word store -> mem_E=0 immediately, no resp_valid, req_ready=1, and only bytes 0..1 written.
